// File: rtl/inert_pkg.sv
// Shared types and SPI command words for the inertial sensor front-end.
package inert_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  // Init writes: INT on data-ready, accel 208 Hz +/-2 g, gyro 208 Hz 250 dps, rounding on
  localparam logic [15:0] CMD_INIT1 = 16'h0D02;
  localparam logic [15:0] CMD_INIT2 = 16'h1053;
  localparam logic [15:0] CMD_INIT3 = 16'h1150;
  localparam logic [15:0] CMD_INIT4 = 16'h1460;

  // Byte reads: pitch rate L/H, Z acceleration L/H
  localparam logic [15:0] CMD_RD_PL = 16'hA400;
  localparam logic [15:0] CMD_RD_PH = 16'hA500;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

endpackage

// File: rtl/inert_intf.sv
// Inertial sensor front-end: configures the sensor over SPI after power-up, then reads
// pitch rate and Z acceleration on each data-ready interrupt.
import inert_pkg::*;

module inert_intf #(
  parameter int unsigned INIT_WAIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] az
);

  state_t                 state_q, state_d;
  logic [INIT_WAIT_W-1:0] cnt_q, cnt_d;
  logic                   INT_ff1, INT_ff2;
  logic                   wrt_q, wrt_d;
  logic [15:0]            cmd_q, cmd_d;
  logic                   vld_q, vld_d;
  logic [7:0]             pl_q, pl_d, ph_q, ph_d, al_q, al_d, ah_q, ah_d;
  logic [15:0]            ptch_q, ptch_d, az_q, az_d;

  // Only the low byte of each read-back carries register data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_WAIT;
      cnt_q   <= '0;
      INT_ff1 <= 1'b0;
      INT_ff2 <= 1'b0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      vld_q   <= 1'b0;
      pl_q    <= 8'h00;
      ph_q    <= 8'h00;
      al_q    <= 8'h00;
      ah_q    <= 8'h00;
      ptch_q  <= 16'h0000;
      az_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      INT_ff1 <= INT;
      INT_ff2 <= INT_ff1;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      pl_q    <= pl_d;
      ph_q    <= ph_d;
      al_q    <= al_d;
      ah_q    <= ah_d;
      ptch_q  <= ptch_d;
      az_q    <= az_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    pl_d    = pl_q;
    ph_d    = ph_q;
    al_d    = al_q;
    ah_d    = ah_q;
    ptch_d  = ptch_q;
    az_d    = az_q;

    unique case (state_q)
      INIT_WAIT: begin
        // Counter wraps back to 0 on exit and is idle afterwards.
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = INIT1;
          wrt_d   = 1'b1;
          cmd_d   = CMD_INIT1;
        end
      end
      INIT1: begin
        if (done) begin
          state_d = INIT2;
          wrt_d   = 1'b1;
          cmd_d   = CMD_INIT2;
        end
      end
      INIT2: begin
        if (done) begin
          state_d = INIT3;
          wrt_d   = 1'b1;
          cmd_d   = CMD_INIT3;
        end
      end
      INIT3: begin
        if (done) begin
          state_d = INIT4;
          wrt_d   = 1'b1;
          cmd_d   = CMD_INIT4;
        end
      end
      INIT4: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (INT_ff2) begin
          state_d = RD_PL;
          wrt_d   = 1'b1;
          cmd_d   = CMD_RD_PL;
        end
      end
      RD_PL: begin
        if (done) begin
          pl_d    = rd_data[7:0];
          state_d = RD_PH;
          wrt_d   = 1'b1;
          cmd_d   = CMD_RD_PH;
        end
      end
      RD_PH: begin
        if (done) begin
          ph_d    = rd_data[7:0];
          state_d = RD_AL;
          wrt_d   = 1'b1;
          cmd_d   = CMD_RD_AL;
        end
      end
      RD_AL: begin
        if (done) begin
          al_d    = rd_data[7:0];
          state_d = RD_AH;
          wrt_d   = 1'b1;
          cmd_d   = CMD_RD_AH;
        end
      end
      RD_AH: begin
        if (done) begin
          // Both words load on the same edge that raises vld, so they never tear.
          ah_d    = rd_data[7:0];
          state_d = IDLE;
          vld_d   = 1'b1;
          ptch_d  = {ph_q, pl_q};
          az_d    = {ah_d, al_q};
        end
      end
      default: begin
        state_d = INIT_WAIT;
      end
    endcase
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptch_q;
  assign az      = az_q;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI slave plus sensor register model, table vectors, corner
// sequences and randomized sample sets checked against an arithmetic reference.
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] az;

  always #5 clk = ~clk;

  inert_intf #(.INIT_WAIT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .vld     (vld),
    .ptch_rt (ptch_rt),
    .az      (az)
  );

  typedef struct packed {logic [7:0] pl, ph, al, ah;} set_t;
  typedef struct {
    logic [7:0]  pl, ph, al, ah;
    logic [15:0] exp_p, exp_a;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cur_lat = 39;
  bit          int_force = 1'b0;
  bit          spurious_req = 1'b0;
  int          sets_pending = 0;
  set_t        sets[$];
  set_t        cur_set = '0;
  logic [15:0] cmd_log[$];
  logic [15:0] vp_q[$];
  logic [15:0] va_q[$];
  int          vld_total = 0;
  logic [15:0] init_cmds[4];
  logic [15:0] rd_cmds[4];
  vec_t        tbl[4];

  // Sensor raises INT while it has an unread sample (or when forced for glitch tests).
  assign INT = int_force | (sets_pending != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sensor_byte(input logic [15:0] c);
    case (c[14:8])
      7'h24:   return cur_set.pl;
      7'h25:   return cur_set.ph;
      7'h2C:   return cur_set.al;
      7'h2D:   return cur_set.ah;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic sensor_push(input logic [7:0] pl, ph, al, ah);
    set_t s;
    s.pl = pl; s.ph = ph; s.al = al; s.ah = ah;
    sets.push_back(s);
    sets_pending++;
  endtask

  // SPI slave: done arrives cur_lat+1 clocks after wrt; sample latched when pitch-L read starts.
  initial begin : spi_slave
    logic        pend;
    logic [15:0] pend_cmd;
    int unsigned lat_cnt;
    pend = 1'b0; pend_cmd = '0; lat_cnt = 0;
    done = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (spurious_req) begin
          done = 1'b1;
          rd_data = 16'hBEEF;
          spurious_req = 1'b0;
        end else if (pend) begin
          if (lat_cnt == 0) begin
            check("cmd_stable", cmd, pend_cmd);
            done = 1'b1;
            rd_data = pend_cmd[15] ? {8'($urandom), sensor_byte(pend_cmd)} : 16'($urandom);
            pend = 1'b0;
          end else begin
            lat_cnt--;
          end
        end
        if (wrt) begin
          check("wrt_while_outstanding", 32'(pend), 0);
          cmd_log.push_back(cmd);
          pend = 1'b1;
          pend_cmd = cmd;
          lat_cnt = cur_lat;
          if (cmd == 16'hA400 && sets_pending > 0) begin
            cur_set = sets.pop_front();
            sets_pending--;
          end
        end
      end
    end
  end

  // Output monitor: records vld samples, forbids back-to-back vld and unstrobed changes.
  initial begin : out_mon
    logic        prev_vld;
    logic [15:0] prev_p, prev_a;
    prev_vld = 1'b0; prev_p = '0; prev_a = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (vld) begin
          vp_q.push_back(ptch_rt);
          va_q.push_back(az);
          vld_total++;
          check("vld_spacing", 32'(prev_vld), 0);
        end else if (ptch_rt !== prev_p || az !== prev_a) begin
          check("outputs_change_without_vld", {ptch_rt, az}, {prev_p, prev_a});
        end
      end
      prev_vld = vld;
      prev_p   = ptch_rt;
      prev_a   = az;
    end
  end

  task automatic wait_cmds(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cmd_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(cmd_log.size() >= n), 1);
  endtask

  task automatic wait_vld(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (vp_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(vp_q.size() >= n), 1);
  endtask

  task automatic check_sample(input string name, input logic [15:0] ep, input logic [15:0] ea);
    logic [15:0] p, a;
    p = (vp_q.size() > 0) ? vp_q.pop_front() : 16'hxxxx;
    a = (va_q.size() > 0) ? va_q.pop_front() : 16'hxxxx;
    check({name, "_ptch_rt"}, p, ep);
    check({name, "_az"}, a, ea);
  endtask

  task automatic check_reads(input int base);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_cmd%0d", i), cmd_log[base + i], rd_cmds[i]);
    end
  endtask

  task automatic check_init(input int base);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init_cmd%0d", i), cmd_log[base + i], init_cmds[i]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wrt"}, 32'(wrt), 0);
    check({name, "_cmd"}, 32'(cmd), 0);
    check({name, "_vld"}, 32'(vld), 0);
    check({name, "_ptch_rt"}, 32'(ptch_rt), 0);
    check({name, "_az"}, 32'(az), 0);
  endtask

  task automatic measure_init_wait();
    int n;
    n = 0;
    while (!wrt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("init_wait_clocks", n, 16);
  endtask

  initial begin : main
    int          base;
    int          nsets;
    logic [7:0]  b[4];
    logic [15:0] exp_p[$];
    logic [15:0] exp_a[$];

    init_cmds = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    rd_cmds   = '{16'hA400, 16'hA500, 16'hAC00, 16'hAD00};
    tbl[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
    tbl[1] = '{8'h01, 8'h80, 8'hFF, 8'h7F, 16'h8001, 16'h7FFF};
    tbl[2] = '{8'h00, 8'h00, 8'h01, 8'h00, 16'h0000, 16'h0001};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 16'hFFFF, 16'h8000};

    // Power-up
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    measure_init_wait();
    wait_cmds(4, 1000, "init_done");
    check_init(0);
    repeat (300) @(negedge clk);
    check("init_wrt_count", cmd_log.size(), 4);
    check("vld_during_init", vld_total, 0);

    // Table vectors, each with INT-to-wrt latency check
    for (int i = 0; i < 4; i++) begin
      base = cmd_log.size();
      cur_lat = (i == 0) ? 39 : 3 + 7 * i;
      sensor_push(tbl[i].pl, tbl[i].ph, tbl[i].al, tbl[i].ah);
      @(negedge clk);
      check("int_lat_c1", 32'(wrt), 0);
      @(negedge clk);
      check("int_lat_c2", 32'(wrt), 0);
      @(negedge clk);
      check("int_lat_c3", 32'(wrt), 1);
      wait_vld(1, 2000, "tbl_vld");
      check_sample($sformatf("tbl%0d", i), tbl[i].exp_p, tbl[i].exp_a);
      check_reads(base);
    end

    // Spurious done while idle
    repeat (20) @(negedge clk);
    base = cmd_log.size();
    nsets = vld_total;
    spurious_req = 1'b1;
    repeat (10) @(negedge clk);
    check("spurious_no_wrt", cmd_log.size(), base);
    check("spurious_no_vld", vld_total, nsets);
    check("spurious_ptch_held", ptch_rt, 16'hFFFF);
    check("spurious_az_held", az, 16'h8000);

    // INT held high across two samples
    base = cmd_log.size();
    cur_lat = 5;
    sensor_push(8'h01, 8'h80, 8'hFF, 8'h7F);
    sensor_push(8'h02, 8'h00, 8'h00, 8'h00);
    wait_vld(2, 2000, "held_vld");
    check_sample("held0", 16'h8001, 16'h7FFF);
    check_sample("held1", 16'h0002, 16'h0000);
    repeat (100) @(negedge clk);
    check("held_rd_count", cmd_log.size() - base, 8);
    check_reads(base);
    check_reads(base + 4);

    // INT glitch during RD_PH
    base = cmd_log.size();
    cur_lat = 20;
    sensor_push(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    wait_cmds(base + 2, 500, "rdph_reached");
    int_force = 1'b1;
    repeat (3) @(negedge clk);
    int_force = 1'b0;
    wait_vld(1, 2000, "rdph_vld");
    check_sample("rdph", 16'hA55A, 16'hC33C);
    repeat (200) @(negedge clk);
    check("rdph_rd_count", cmd_log.size() - base, 4);

    // Reset in RD_AL after two bytes, with INT glitch during INIT2 of the re-run
    base = cmd_log.size();
    cur_lat = 30;
    sensor_push(8'h11, 8'h22, 8'h33, 8'h44);
    wait_cmds(base + 3, 500, "rdal_reached");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = cmd_log.size();
    measure_init_wait();
    wait_cmds(base + 2, 500, "reinit2_reached");
    int_force = 1'b1;
    repeat (3) @(negedge clk);
    int_force = 1'b0;
    wait_cmds(base + 4, 1000, "reinit_done");
    check_init(base);
    repeat (300) @(negedge clk);
    check("reinit_wrt_count", cmd_log.size() - base, 4);
    check("aborted_no_vld", vp_q.size(), 0);
    base = cmd_log.size();
    sensor_push(8'h99, 8'h88, 8'h77, 8'h66);
    wait_vld(1, 2000, "post_reset_vld");
    check_sample("post_reset", 16'h8899, 16'h6677);
    check_reads(base);

    // Randomized samples against arithmetic model
    for (int it = 0; it < 15; it++) begin
      base = cmd_log.size();
      cur_lat = $urandom_range(1, 15);
      nsets = $urandom_range(1, 2);
      for (int s = 0; s < nsets; s++) begin
        for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
        sensor_push(b[0], b[1], b[2], b[3]);
        exp_p.push_back(16'(b[1]) * 16'd256 + 16'(b[0]));
        exp_a.push_back(16'(b[3]) * 16'd256 + 16'(b[2]));
      end
      wait_vld(nsets, 3000, "rand_vld");
      for (int s = 0; s < nsets; s++) begin
        check_sample($sformatf("rand%0d_%0d", it, s), exp_p.pop_front(), exp_a.pop_front());
        check_reads(base + 4 * s);
      end
      repeat (20) @(negedge clk);
      check("rand_rd_count", cmd_log.size() - base, 4 * nsets);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inert_intf.md
# inert_intf

Inertial sensor front-end: drives the 16-bit SPI master transaction port to configure the 6-axis inertial sensor after power-up, then, on every data-ready interrupt, reads pitch rate and Z acceleration as four byte reads. It assembles them into two signed 16-bit words and issues a one-cycle valid strobe. It sits directly upstream of the SPI master (issues `wrt`/`cmd`, consumes `done`/`rd_data`) and feeds the incline/torque computation downstream.

## Interface
- `INIT_WAIT_W`, 16: width of power-up wait counter; wait is 2^INIT_WAIT_W clocks (benches use 4).
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `INT` input 1: sensor data-ready, asynchronous, active-high level.
- `done` input 1: SPI transaction complete, one-cycle pulse.
- `rd_data` input 16: SPI read-back; byte of interest in [7:0].
- `wrt` output 1: start SPI transaction, one-cycle pulse.
- `cmd` output 16: SPI command word {R/W_n-bit, addr[6:0], data[7:0]}; bit 15 = 1 means read.
- `vld` output 1: new `ptch_rt`/`az` available, one-cycle pulse.
- `ptch_rt` output 16: signed pitch rate {H,L}.
- `az` output 16: signed Z acceleration {H,L}.

## Operation
- Init write sequence, in order:
  - 0x0D02: INT on data-ready.
  - 0x1053: accel 208 Hz, ±2 g.
  - 0x1150: gyro 208 Hz, 250 dps.
  - 0x1460: rounding on.
- Read sequence, in order:
  - 0xA400: pitch L.
  - 0xA500: pitch H.
  - 0xAC00: az L.
  - 0xAD00: az H.
- States:
  - INIT_WAIT: counter runs from 0; at all-ones, go to INIT1 and pulse `wrt` with cmd 0x0D02.
  - INIT1..INIT4: hold `cmd`. On `done`, pulse `wrt` with the next init command and advance. INIT4 goes to IDLE on `done` with no `wrt`.
  - IDLE: when `INT_ff2`==1, pulse `wrt` with 0xA400 and go to RD_PL.
  - RD_PL, RD_PH, RD_AL, RD_AH: on `done`, capture `rd_data[7:0]` into the matching holding byte. RD_PL, RD_PH and RD_AL then pulse `wrt` with the next read command and advance. RD_AH goes to IDLE and asserts `vld` the next cycle.
- `ptch_rt` and `az` update only together, in the same cycle `vld` is high. They are never partially updated.
- `INT` is synchronized through two flops (`INT_ff1`, `INT_ff2`). It is sampled only in IDLE; it is ignored during INIT and read states. The sensor clears INT when its data is read.
- `done` outside an INIT or RD state is ignored.
- `wrt` is never asserted while a transaction is outstanding.
- Reset mid-operation: every state and holding register is cleared, the FSM returns to INIT_WAIT with the counter at 0, and the full init sequence is re-run.

## Timing
- Reset values: `wrt`=0, `cmd`=0x0000, `vld`=0, `ptch_rt`=0, `az`=0, state=INIT_WAIT. Holding bytes and sync flops are also 0.
- `cmd` is registered. It is valid in the same cycle as `wrt` and stable until the matching `done`.
- `wrt` is registered and rises the cycle after the enabling event. This applies both to the counter reaching all-ones and to `done`.
- INT to `wrt` latency: 3 clocks from the `INT` rising edge (2 sync + 1 registered `wrt`).
- Final `done` (RD_AH) to `vld`: 1 clock. Outputs are valid from the `vld` cycle onward.
- If `INT` is still high when returning to IDLE, a new read starts on the first IDLE cycle. There are no back-to-back `vld` cycles; the minimum `vld` spacing is 4 SPI transactions.
- Counter wraps only once. It is not used after INIT_WAIT.

## Structure
- Package `inert_pkg`:
  - `state_t` enum: INIT_WAIT, INIT1..INIT4, IDLE, RD_PL, RD_PH, RD_AL, RD_AH.
  - Localparams for the 4 init command words.
  - Localparams for the 4 read command words.
- Single module, no sub-module. The INT synchronizer, wait counter and 4 holding byte registers are inline.
- Top level instantiates `inert_intf` beside the SPI master and wires `wrt`/`cmd`/`done`/`rd_data` directly.

## Test plan
- Reset then run with `INIT_WAIT_W`=4, SPI model returning `done` 40 clocks after each `wrt` -> exactly 4 `wrt` pulses with cmd 0x0D02, 0x1053, 0x1150, 0x1460 in order, then FSM in IDLE, `vld` never high.
- After init, raise `INT`; model returns bytes 0x34, 0x12, 0xCD, 0xAB -> cmds 0xA400, 0xA500, 0xAC00, 0xAD00, then `vld` one cycle with `ptch_rt`=0x1234 and `az`=0xABCD.
- `INT` held high across two sets (0x01,0x80,0xFF,0x7F then 0x02,0x00,0x00,0x00) -> two `vld` pulses:
  - first: `ptch_rt`=0x8001, `az`=0x7FFF;
  - second: `ptch_rt`=0x0002, `az`=0x0000;
  - outputs unchanged between the two pulses.
- `INT` pulsed during INIT2 and during RD_PH -> no extra `wrt`, no sequence restart; `wrt` count per sequence stays 4.
- Assert `rst_n` low during RD_AL after 2 bytes received -> outputs 0 immediately, and after release the full init sequence repeats before any read.
- Spurious `done` in IDLE -> no `wrt`, no `vld`, outputs held.
